// File: rtl/bouncing_box_renderer_if.sv
// Pixel stream between the VGA timing driver, the box renderer and the display side.
// Latency 2 pixelEn strobes from inputs to outputs; no backpressure, pixelEn is a pure strobe.
interface bouncing_box_renderer_if;
    logic       pixelEn;
    logic [9:0] xOrd;
    logic [9:0] yOrd;
    logic       visible;
    logic       hSyncIn;
    logic       vSyncIn;
    logic [5:0] rgb;
    logic       hSyncOut;
    logic       vSyncOut;
    logic       visibleOut;

    modport master (
        output pixelEn, xOrd, yOrd, visible, hSyncIn, vSyncIn,
        input  rgb, hSyncOut, vSyncOut, visibleOut
    );

    modport slave (
        input  pixelEn, xOrd, yOrd, visible, hSyncIn, vSyncIn,
        output rgb, hSyncOut, vSyncOut, visibleOut
    );
endinterface

// File: rtl/bouncing_box_renderer.sv
// Draws a bordered box bouncing once per frame; RGB and syncs leave 2 pixelEn strobes after entry.
// No backpressure: every register advances only on pixelEn and holds otherwise.
module bouncing_box_renderer #(
    parameter int          RES_X    = 500,
    parameter int          RES_Y    = 500,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter logic [5:0]  BG_COLOR = 6'h01
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_run,
    bouncing_box_renderer_if.slave    pix,
    output logic [7:0]                o_frameCount
);

    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] MAX_X  = 11'(RES_X - BOX_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(RES_Y - BOX_SIZE);

    // Returns {next_dir, next_pos}; dir 1 means moving towards larger coordinates.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                           input logic [10:0] maxp);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + STEP_W >= maxp) bounce = {1'b0, maxp[9:0]};
            else                    bounce = {1'b1, 10'(p + STEP_W)};
        end else begin
            if (p <= STEP_W)        bounce = {1'b1, 10'd0};
            else                    bounce = {1'b0, 10'(p - STEP_W)};
        end
    endfunction

    logic [9:0]  r_box_x;
    logic [9:0]  r_box_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic        r_vsync_prev;
    logic [7:0]  r_frame_cnt;

    logic        r_in_box1;
    logic        r_border1;
    logic        r_vis1;
    logic        r_hs1;
    logic        r_vs1;

    logic [5:0]  r_rgb2;
    logic        r_hs2;
    logic        r_vs2;
    logic        r_vis2;

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_bx_end;
    logic [10:0] w_by_end;
    logic        w_in_box;
    logic        w_border;
    logic        w_tick;
    logic [10:0] w_bounce_x;
    logic [10:0] w_bounce_y;
    logic [5:0]  w_colour;

    assign w_x      = {1'b0, pix.xOrd};
    assign w_y      = {1'b0, pix.yOrd};
    assign w_bx     = {1'b0, r_box_x};
    assign w_by     = {1'b0, r_box_y};
    assign w_bx_end = w_bx + BOX_W;
    assign w_by_end = w_by + BOX_W;

    assign w_in_box = (w_x >= w_bx) && (w_x < w_bx_end) &&
                      (w_y >= w_by) && (w_y < w_by_end);
    assign w_border = w_in_box &&
                      ((w_x == w_bx) || (w_x == w_bx_end - 11'd1) ||
                       (w_y == w_by) || (w_y == w_by_end - 11'd1));

    // Falling edge of vsync marks the start of vertical blanking: safe moment to move the box.
    assign w_tick     = r_vsync_prev & ~pix.vSyncIn;
    assign w_bounce_x = bounce(r_box_x, r_dir_x, MAX_X);
    assign w_bounce_y = bounce(r_box_y, r_dir_y, MAX_Y);

    always_comb begin
        w_colour = BG_COLOR;
        if (!r_vis1)         w_colour = 6'h00;
        else if (r_border1)  w_colour = 6'h3F;
        else if (r_in_box1)  w_colour = r_frame_cnt[7:2];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_box_x      <= '0;
            r_box_y      <= '0;
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b1;
            r_vsync_prev <= 1'b1;
            r_frame_cnt  <= '0;
            r_in_box1    <= 1'b0;
            r_border1    <= 1'b0;
            r_vis1       <= 1'b0;
            r_hs1        <= 1'b1;
            r_vs1        <= 1'b1;
            r_rgb2       <= '0;
            r_hs2        <= 1'b1;
            r_vs2        <= 1'b1;
            r_vis2       <= 1'b0;
        end else if (pix.pixelEn) begin
            r_vsync_prev <= pix.vSyncIn;
            if (w_tick) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                if (i_run) begin
                    r_box_x <= w_bounce_x[9:0];
                    r_dir_x <= w_bounce_x[10];
                    r_box_y <= w_bounce_y[9:0];
                    r_dir_y <= w_bounce_y[10];
                end
            end
            r_in_box1 <= w_in_box;
            r_border1 <= w_border;
            r_vis1    <= pix.visible;
            r_hs1     <= pix.hSyncIn;
            r_vs1     <= pix.vSyncIn;
            r_rgb2    <= w_colour;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_vis2    <= r_vis1;
        end
    end

    assign pix.rgb        = r_rgb2;
    assign pix.hSyncOut   = r_hs2;
    assign pix.vSyncOut   = r_vs2;
    assign pix.visibleOut = r_vis2;
    assign o_frameCount   = r_frame_cnt;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Randomised scoreboard bench for bouncing_box_renderer against a frame-level box model.
module tb_bouncing_box_renderer;
    localparam int         RES_X = 500;
    localparam int         RES_Y = 500;
    localparam int         BOX   = 32;
    localparam int         STEP  = 2;
    localparam logic [5:0] BG    = 6'h01;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] fc;

    always #5 clk = ~clk;

    bouncing_box_renderer_if pix();

    bouncing_box_renderer #(
        .RES_X(RES_X), .RES_Y(RES_Y), .BOX_SIZE(BOX), .STEP(STEP), .BG_COLOR(BG)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_run(run),
        .pix(pix),
        .o_frameCount(fc)
    );

    typedef struct {
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        logic       vis;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: box corner, direction, last vsync and frame count
    int m_bx, m_by, m_fc;
    bit m_dxp, m_dyp, m_vprev;
    bit hs_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void move(inout int pos, inout bit fwd, input int maxp);
        if (fwd) begin
            if (pos + STEP >= maxp) begin pos = maxp; fwd = 1'b0; end
            else pos = pos + STEP;
        end else begin
            if (pos <= STEP) begin pos = 0; fwd = 1'b1; end
            else pos = pos - STEP;
        end
    endfunction

    task automatic model_reset();
        m_bx = 0; m_by = 0; m_dxp = 1'b1; m_dyp = 1'b1; m_vprev = 1'b1; m_fc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pix.pixelEn = 1'($urandom_range(0, 1));
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic strobe(input int x, input int y, input bit vis, input bit hs, input bit vs);
        exp_t e;
        int   xi, yi;
        bit   inb, bord, tick;
        @(negedge clk);
        rst = 1'b0;
        pix.pixelEn = 1'b1;
        pix.xOrd    = 10'(x);
        pix.yOrd    = 10'(y);
        pix.visible = vis;
        pix.hSyncIn = hs;
        pix.vSyncIn = vs;
        xi = x & 1023;
        yi = y & 1023;
        inb  = (xi >= m_bx) && (xi < m_bx + BOX) && (yi >= m_by) && (yi < m_by + BOX);
        bord = inb && (xi == m_bx || xi == m_bx + BOX - 1 || yi == m_by || yi == m_by + BOX - 1);
        tick = m_vprev && !vs;
        m_vprev = vs;
        if (tick) begin
            m_fc = (m_fc + 1) % 256;
            if (run) begin
                move(m_bx, m_dxp, RES_X - BOX);
                move(m_by, m_dyp, RES_Y - BOX);
            end
        end
        e.vis = vis;
        e.hs  = hs;
        e.vs  = vs;
        if (!vis)      e.rgb = 6'h00;
        else if (bord) e.rgb = 6'h3F;
        else if (inb)  e.rgb = 6'(m_fc / 4);
        else           e.rgb = BG;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0;
            pix.pixelEn = 1'b0;
            pix.xOrd    = 10'($urandom_range(0, 1023));
            pix.yOrd    = 10'($urandom_range(0, 1023));
            pix.visible = 1'($urandom_range(0, 1));
            pix.hSyncIn = 1'($urandom_range(0, 1));
            pix.vSyncIn = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic near_box_pixel();
        strobe(m_bx + $urandom_range(0, 37) - 3, m_by + $urandom_range(0, 37) - 3,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic tick_frame();
        strobe($urandom_range(0, 600), $urandom_range(0, 600), 1'b0, 1'b1, 1'b0);
        strobe($urandom_range(0, 600), $urandom_range(0, 600), 1'b0, 1'b1, 1'b1);
        near_box_pixel();
    endtask

    task automatic probe_box();
        strobe(m_bx,           m_by,           1'b1, 1'b1, 1'b1);
        strobe(m_bx - 1,       m_by + 1,       1'b1, 1'b0, 1'b1);
        strobe(m_bx + 1,       m_by + 1,       1'b1, 1'b1, 1'b1);
        strobe(m_bx + BOX - 1, m_by + BOX - 1, 1'b1, 1'b0, 1'b1);
        strobe(m_bx + BOX,     m_by + 5,       1'b1, 1'b1, 1'b1);
        strobe(m_bx + 5,       m_by + BOX,     1'b1, 1'b0, 1'b1);
        strobe(m_bx + 5,       m_by + 5,       1'b1, 1'b1, 1'b1);
    endtask

    // Monitor: pops one expectation per strobe once the 2-deep pipeline has filled
    initial begin : monitor
        int   strobes;
        bit   en, r;
        exp_t e;
        strobes = 0;
        forever begin
            @(posedge clk);
            en = pix.pixelEn;
            r  = rst;
            #1;
            if (r) begin
                strobes = 0;
                check("rst_rgb", int'(pix.rgb), 0);
                check("rst_hsync", int'(pix.hSyncOut), 1);
                check("rst_vsync", int'(pix.vSyncOut), 1);
                check("rst_visible", int'(pix.visibleOut), 0);
                check("rst_frame_count", int'(fc), 0);
            end else if (en) begin
                strobes++;
                check("frame_count", int'(fc), m_fc);
                if (strobes >= 2) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_empty: output strobe with no expectation at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        last_exp = e;
                        check("rgb", int'(pix.rgb), int'(e.rgb));
                        check("hsync_out", int'(pix.hSyncOut), int'(e.hs));
                        check("vsync_out", int'(pix.vSyncOut), int'(e.vs));
                        check("visible_out", int'(pix.visibleOut), int'(e.vis));
                    end
                end
            end else if (strobes >= 2) begin
                check("hold_rgb", int'(pix.rgb), int'(last_exp.rgb));
                check("hold_hsync", int'(pix.hSyncOut), int'(last_exp.hs));
                check("hold_visible", int'(pix.visibleOut), int'(last_exp.vis));
                check("hold_frame_count", int'(fc), m_fc);
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        run = 1'b1;
        pix.pixelEn = 1'b0;
        pix.xOrd    = '0;
        pix.yOrd    = '0;
        pix.visible = 1'b0;
        pix.hSyncIn = 1'b1;
        pix.vSyncIn = 1'b1;
        model_reset();
        do_reset();

        // Box at origin: corner border, interior at frame 0, background, then invisible pixel
        strobe(0, 0, 1'b1, 1'b1, 1'b1);
        strobe(5, 5, 1'b1, 1'b1, 1'b1);
        strobe(40, 40, 1'b1, 1'b1, 1'b1);
        strobe(1, 1, 1'b0, 1'b1, 1'b1);

        // Toggling hsync with idle gaps, including a 5-cycle freeze
        hs_t = 1'b0;
        for (int i = 0; i < 24; i++) begin
            strobe($urandom_range(0, 60), $urandom_range(0, 60),
                   1'($urandom_range(0, 1)), hs_t, 1'b1);
            hs_t = ~hs_t;
            if (i % 6 == 3) idle(5);
            else idle($urandom_range(0, 2));
        end

        // Bounce at the right edge: 234 ticks reach 468, the 235th turns back
        run = 1'b1;
        for (int t = 0; t < 234; t++) tick_frame();
        probe_box();
        strobe(468, m_by + 2, 1'b1, 1'b1, 1'b1);
        strobe(467, m_by + 2, 1'b1, 1'b1, 1'b1);
        tick_frame();
        probe_box();
        strobe(466, m_by + 2, 1'b1, 1'b1, 1'b1);

        // Frozen box while frames still count
        run = 1'b0;
        for (int t = 0; t < 10; t++) tick_frame();
        probe_box();

        for (int t = 0; t < 30; t++) begin
            run = 1'($urandom_range(0, 1));
            tick_frame();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        probe_box();

        // Reset mid-frame, first strobe ticks, then interior colour at frame 8 and wrap at 256
        run = 1'b1;
        do_reset();
        strobe(3, 3, 1'b1, 1'b1, 1'b0);
        strobe(3, 3, 1'b1, 1'b1, 1'b1);
        for (int t = 1; t < 8; t++) tick_frame();
        strobe(m_bx + 6, m_by + 6, 1'b1, 1'b1, 1'b1);
        probe_box();
        for (int t = 8; t < 256; t++) tick_frame();
        probe_box();
        tick_frame();
        probe_box();

        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        strobe(0, 0, 1'b0, 1'b1, 1'b1);
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
